mul_ctrl: RTL and testbench

//  Sequencer between the execute stage and the shared 32x32 unsigned iterative multiplier.

---
 rtl/mul_pkg.sv | 10 +
 rtl/mul_sign_fix.sv | 13 +
 rtl/mul_ctrl.sv | 113 +++++++++++
 tb/tb_mul_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, opcode/state enums and result-half select for mul_ctrl
package mul_pkg;
  localparam int XLEN = 32;
  localparam int PROD = 64;
  typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} mul_op_t;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} mul_state_t;
  function automatic logic [XLEN-1:0] pick(input mul_op_t op, input logic [PROD-1:0] p);
    return op == MUL ? p[XLEN-1:0] : p[PROD-1:XLEN];
  endfunction
endpackage

// File: rtl/mul_sign_fix.sv
// mul_sign_fix: sign detect and two's-complement conditional negate (magnitude or sign correction)
module mul_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         sgn_en,
  input  logic         inv,
  output logic [W-1:0] y,
  output logic         s
);
  assign s = sgn_en & x[W-1];
  assign y = (s | inv) ? -x : x;
endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: RV32M multiply sequencer around a shared unsigned iterative multiplier.
// MUL_REUSE_EN: reuse the last product when operands and signedness class repeat.
module mul_ctrl
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_req,
  input  logic [1:0]      mul_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            mul_flush,
  output logic            mul_ready,
  output logic            mul_done,
  output logic [XLEN-1:0] mul_result,
  output logic            mult_load,
  output logic [XLEN-1:0] mult_a,
  output logic [XLEN-1:0] mult_b,
  input  logic [PROD-1:0] mult_product,
  input  logic            mult_resp
);
  mul_state_t      state;
  mul_op_t         op, req_op;
  logic            drain, neg, done_r, sa, sb, sa_en, sb_en, hit, p_sgn_unused;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [PROD-1:0] p_fix, last_p;
  assign req_op = mul_op_t'(mul_op);
  assign sa_en = req_op != MULHU;
  assign sb_en = !mul_op[1];
  assign mul_done = done_r & ~mul_flush;
  mul_sign_fix #(.W(XLEN)) u_fix_a (.x(rs1_data), .sgn_en(sa_en), .inv(1'b0), .y(mag_a), .s(sa));
  mul_sign_fix #(.W(XLEN)) u_fix_b (.x(rs2_data), .sgn_en(sb_en), .inv(1'b0), .y(mag_b), .s(sb));
  mul_sign_fix #(.W(PROD)) u_fix_p (.x(mult_product), .sgn_en(1'b0), .inv(neg), .y(p_fix), .s(p_sgn_unused));
`ifdef MUL_REUSE_EN
  logic [XLEN-1:0] last_rs1, last_rs2;
  logic [1:0]      last_cls;
  logic            valid;
  assign hit = valid && rs1_data == last_rs1 && rs2_data == last_rs2 &&
               ({sa_en, sb_en} == last_cls || req_op == MUL);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_rs1 <= '0;
      last_rs2 <= '0;
      last_cls <= '0;
      last_p <= '0;
      valid <= 1'b0;
    end else if (mul_flush) valid <= 1'b0;
    else if (state == IDLE && mul_req && !hit) begin
      last_rs1 <= rs1_data;
      last_rs2 <= rs2_data;
      last_cls <= {sa_en, sb_en};
      valid <= 1'b0;
    end else if (state == WAIT && mult_resp && !drain) begin
      last_p <= p_fix;
      valid <= 1'b1;
    end
`else
  assign hit = 1'b0;
  assign last_p = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op <= MUL;
      mul_ready <= 1'b1;
      done_r <= 1'b0;
      mul_result <= '0;
      mult_load <= 1'b0;
      mult_a <= '0;
      mult_b <= '0;
      drain <= 1'b0;
      neg <= 1'b0;
    end else begin
      mult_load <= 1'b0;
      done_r <= 1'b0;
      case (state)
        IDLE: if (mul_req && !mul_flush) begin
          mul_ready <= 1'b0;
          if (hit) begin
            mul_result <= pick(req_op, last_p);
            done_r <= 1'b1;
            state <= FINISH;
          end else begin
            op <= req_op;
            mult_a <= mag_a;
            mult_b <= mag_b;
            neg <= sa ^ sb;
            mult_load <= 1'b1;
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          drain <= mul_flush;
          state <= WAIT;
        end
        WAIT: if (mult_resp) begin
          if (drain || mul_flush) begin
            drain <= 1'b0;
            mul_ready <= 1'b1;
            state <= IDLE;
          end else begin
            mul_result <= pick(op, p_fix);
            done_r <= 1'b1;
            state <= FINISH;
          end
        end else if (mul_flush) drain <= 1'b1;
        FINISH: begin
          mul_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: randomized and directed checks of mul_ctrl against a signed-arithmetic reference
module tb_mul_ctrl;
  logic        clk = 0, rst_n = 0, mul_req = 0, mul_flush = 0, mult_resp = 0;
  logic [1:0]  mul_op = 0;
  logic [31:0] rs1_data = 0, rs2_data = 0;
  logic        mul_ready, mul_done, mult_load;
  logic [31:0] mul_result, mult_a, mult_b;
  logic [63:0] mult_product = 0;
  int          checks = 0, errors = 0, loads = 0, mdelay = 0, force_d = -1;
  logic [31:0] cap_a = 0, cap_b = 0;
  logic        r_valid = 0;
  logic [31:0] r_a = 0, r_b = 0;
  logic [1:0]  r_cls = 0;
`ifdef MUL_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  mul_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mul_req(mul_req), .mul_op(mul_op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .mul_flush(mul_flush),
    .mul_ready(mul_ready), .mul_done(mul_done), .mul_result(mul_result),
    .mult_load(mult_load), .mult_a(mult_a), .mult_b(mult_b),
    .mult_product(mult_product), .mult_resp(mult_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op != 2'd3) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = !op[1] ? {{32{b[31]}}, b} : {32'b0, b};
    p = ea * eb;
    return op == 2'd0 ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
    return (sgn && x[31]) ? 32'(-x) : x;
  endfunction

  function automatic logic [1:0] cls_of(input logic [1:0] op);
    return {op != 2'd3, !op[1]};
  endfunction

  // Iterative multiplier stand-in: zero operands answer immediately, others after a random delay
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (mult_load && rst_n) begin
        cap_a = mult_a;
        cap_b = mult_b;
        loads++;
        d = force_d >= 0 ? force_d : ((mult_a == 0 || mult_b == 0) ? 0 : int'($urandom_range(1, 4)));
        mdelay = d;
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1;
        if (rst_n) begin
          check("hold_a", mult_a, cap_a);
          check("hold_b", mult_b, cap_b);
        end
        mult_product = {32'b0, cap_a} * {32'b0, cap_b};
        mult_resp = 1;
        @(posedge clk);
        #1 mult_resp = 0;
        mult_product = {$urandom, $urandom};
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output logic [31:0] res);
    int n, l0;
    logic hit, rdy_bad;
    hit = REUSE && r_valid && a == r_a && b == r_b && (cls_of(op) == r_cls || op == 2'd0);
    l0 = loads;
    check("ready_pre", mul_ready, 1);
    mul_req = 1;
    mul_op = op;
    rs1_data = a;
    rs2_data = b;
    @(negedge clk);
    mul_req = 0;
    n = 1;
    rdy_bad = 0;
    while (!mul_done && n < 60) begin
      if (mul_ready) rdy_bad = 1;
      @(negedge clk);
      n++;
    end
    res = mul_result;
    check("done", mul_done, 1);
    check("ready_busy", rdy_bad, 0);
    check("result", mul_result, ref_res(op, a, b));
    check("latency", n, hit ? 1 : 3 + mdelay);
    check("loads", loads - l0, hit ? 0 : 1);
    if (!hit) begin
      check("mag_a", cap_a, mag(op != 2'd3, a));
      check("mag_b", cap_b, mag(!op[1], b));
      r_valid = 1;
      r_a = a;
      r_b = b;
      r_cls = cls_of(op);
    end
    @(negedge clk);
    check("done_pulse", mul_done, 0);
    check("ready_post", mul_ready, 1);
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic done_any, rdy_any, seen;
    int l0;
    repeat (2) @(negedge clk);
    check("rst_ready", mul_ready, 1);
    check("rst_done", mul_done, 0);
    check("rst_result", mul_result, 0);
    check("rst_load", mult_load, 0);
    check("rst_a", mult_a, 0);
    check("rst_b", mult_b, 0);
    rst_n = 1;
    @(negedge clk);
    run_op(2'd0, 32'd7, -32'sd3, res);
    check("mul_7_m3", res, 32'hFFFFFFEB);
    run_op(2'd1, 32'h80000000, 32'h80000000, res);
    check("mulh_min", res, 32'h40000000);
    run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, res);
    check("mulhu_max", res, 32'hFFFFFFFE);
    run_op(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, res);
    check("mulhsu_m1", res, 32'hFFFFFFFF);
    run_op(2'd0, 32'd0, 32'd5, res);
    check("mul_zero", res, 0);
    check("zero_delay", mdelay, 0);
    // Flush two cycles into WAIT with a slow multiplier
    force_d = 6;
    mul_req = 1; mul_op = 2'd1; rs1_data = 32'd11; rs2_data = 32'd13;
    @(negedge clk);
    mul_req = 0;
    repeat (2) @(negedge clk);
    mul_flush = 1;
    @(negedge clk);
    mul_flush = 0;
    r_valid = 0;
    done_any = 0; rdy_any = 0; seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (mul_done) done_any = 1;
      if (mul_ready) rdy_any = 1;
      if (mult_resp) seen = 1;
      else @(negedge clk);
    end
    check("flush_resp_seen", seen, 1);
    check("flush_ready_low", rdy_any, 0);
    @(negedge clk);
    check("flush_no_done", done_any | mul_done, 0);
    check("flush_ready_back", mul_ready, 1);
    force_d = -1;
    run_op(2'd0, 32'd2, 32'd3, res);
    check("mul_after_flush", res, 6);
    // Request and flush together in IDLE
    l0 = loads;
    mul_req = 1; mul_flush = 1; mul_op = 2'd0; rs1_data = 32'd2; rs2_data = 32'd3;
    @(negedge clk);
    mul_req = 0; mul_flush = 0;
    r_valid = 0;
    check("rf_ready", mul_ready, 1);
    done_any = 0;
    repeat (4) begin
      @(negedge clk);
      if (mul_done) done_any = 1;
    end
    check("rf_no_load", loads - l0, 0);
    check("rf_no_done", done_any, 0);
    run_op(2'd1, 32'd5, 32'd6, res);
    check("mulh_5_6", res, 0);
    run_op(2'd0, 32'd5, 32'd6, res);
    check("mul_5_6", res, 30);
    run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, res);
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, res);
    check("mulh_m1_m1", res, 0);
    // Asynchronous reset in the middle of WAIT
    force_d = 8;
    mul_req = 1; mul_op = 2'd0; rs1_data = 32'd9; rs2_data = 32'd9;
    @(negedge clk);
    mul_req = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_ready", mul_ready, 1);
    check("arst_done", mul_done, 0);
    check("arst_result", mul_result, 0);
    check("arst_load", mult_load, 0);
    check("arst_a", mult_a, 0);
    check("arst_b", mult_b, 0);
    done_any = 0;
    repeat (12) begin
      @(negedge clk);
      if (mul_done) done_any = 1;
    end
    rst_n = 1;
    repeat (2) begin
      @(negedge clk);
      if (mul_done) done_any = 1;
    end
    check("arst_no_done", done_any, 0);
    force_d = -1;
    r_valid = 0;
    a = 0; b = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 5))
          0: a = 0;
          1: a = 32'h80000000;
          2: a = 32'hFFFFFFFF;
          default: a = $urandom;
        endcase
        b = $urandom_range(0, 2) == 0 ? 32'h80000000 : $urandom;
      end
      run_op(2'($urandom_range(0, 3)), a, b, res);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
